// File: rtl/avalon_st_sink_mm_reader.sv
// Avalon-ST sink that frames incoming beats into a FIFO, plus an Avalon-MM slave
// that lets a host pop beats, read framing/status flags and the completed-packet count.
module avalon_st_sink_mm_reader #(
   parameter int DATA_WIDTH    = 32,
   parameter int ERROR_WIDTH   = 2,
   parameter int ADDRESS_WIDTH = 8,
   parameter int DEPTH         = 16
) (
   input  logic                     Clk_CI,
   input  logic                     Reset_RBI,
   output logic                     StReady_SO,
   input  logic                     StValid_SI,
   input  logic                     StSop_SI,
   input  logic                     StEop_SI,
   input  logic                     StEmpty_SI,
   input  logic [ERROR_WIDTH-1:0]   StError_SI,
   input  logic [DATA_WIDTH-1:0]    StData_DI,
   input  logic [ADDRESS_WIDTH-1:0] MmAddress_DI,
   input  logic                     MmRead_SI,
   input  logic                     MmWrite_SI,
   input  logic [DATA_WIDTH-1:0]    MmWritedata_DI,
   output logic [DATA_WIDTH-1:0]    MmReaddata_DO,
   output logic                     MmWaitrequest_SO
);

   localparam int PTR_W   = $clog2(DEPTH);
   localparam int LVL_W   = PTR_W + 1;
   localparam int ENTRY_W = ERROR_WIDTH + 3 + DATA_WIDTH;
   localparam logic [LVL_W-1:0] DEPTH_L  = LVL_W'(DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_ZERO = LVL_W'(0);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
   localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_IN_PKT = 1'b1
   } frame_state_t;

   frame_state_t state_r, state_nxt_s;

   logic [ENTRY_W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0]       level_r;
   logic                   ready_en_r;
   logic                   rd_phase_r, pop_pend_r, unf_pend_r;
   logic [DATA_WIDTH-1:0]  readdata_r;
   logic                   frame_err_r, err_seen_r, underflow_r;
   logic [31:0]            pkt_cnt_r;

   logic [1:0]             addr_s;
   logic                   wr_cycle_s, flush_s, clear_s, pkt_clr_s;
   logic                   st_ready_s, accept_s, push_s, pop_s, rd_start_s;
   logic                   frame_err_set_s, err_seen_set_s, pkt_inc_s, nonempty_s;
   logic [ENTRY_W-1:0]     head_s;
   logic [ERROR_WIDTH-1:0] head_err_s;
   logic [31:0]            status_s;
   logic [DATA_WIDTH-1:0]  rd_mux_s;
   logic                   unused_s;

   assign unused_s   = &{1'b0, MmAddress_DI[ADDRESS_WIDTH-1:2], MmWritedata_DI[DATA_WIDTH-1:2]};
   assign addr_s     = MmAddress_DI[1:0];
   // A read in the same cycle masks any write strobe.
   assign wr_cycle_s = MmWrite_SI & ~MmRead_SI;
   assign flush_s    = wr_cycle_s & (addr_s == 2'd2) & MmWritedata_DI[0];
   assign clear_s    = wr_cycle_s & (addr_s == 2'd2) & MmWritedata_DI[1];
   assign pkt_clr_s  = wr_cycle_s & (addr_s == 2'd3);

   assign nonempty_s = (level_r != LVL_ZERO);
   assign st_ready_s = ready_en_r & (level_r < DEPTH_L) & ~flush_s;
   assign accept_s   = StValid_SI & st_ready_s;
   assign rd_start_s = MmRead_SI & ~rd_phase_r;
   assign pop_s      = rd_phase_r & pop_pend_r & nonempty_s;

   assign head_s     = mem_r[rd_ptr_r];
   assign head_err_s = head_s[ENTRY_W-1 -: ERROR_WIDTH];

   assign StReady_SO       = st_ready_s;
   assign MmWaitrequest_SO = rd_start_s;
   assign MmReaddata_DO    = readdata_r;

   // Framing decisions: which beats are stored and which events are flagged.
   always_comb begin
      state_nxt_s     = state_r;
      push_s          = 1'b0;
      frame_err_set_s = 1'b0;
      pkt_inc_s       = 1'b0;
      if (flush_s) begin
         state_nxt_s = ST_IDLE;
      end else if (accept_s) begin
         case (state_r)
            ST_IDLE: begin
               if (StSop_SI) begin
                  push_s      = 1'b1;
                  pkt_inc_s   = StEop_SI;
                  state_nxt_s = StEop_SI ? ST_IDLE : ST_IN_PKT;
               end else begin
                  frame_err_set_s = 1'b1;
               end
            end
            ST_IN_PKT: begin
               push_s          = 1'b1;
               frame_err_set_s = StSop_SI;
               pkt_inc_s       = StEop_SI;
               state_nxt_s     = StEop_SI ? ST_IDLE : ST_IN_PKT;
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   assign err_seen_set_s = push_s & (StError_SI != {ERROR_WIDTH{1'b0}});

   // Status word and read-data selection, from current-cycle state.
   always_comb begin
      status_s        = 32'h0000_0000;
      status_s[0]     = nonempty_s;
      status_s[1]     = nonempty_s & head_s[DATA_WIDTH];
      status_s[2]     = nonempty_s & head_s[DATA_WIDTH+1];
      status_s[3]     = nonempty_s & head_s[DATA_WIDTH+2];
      status_s[5:4]   = nonempty_s ? 2'(head_err_s) : 2'b00;
      status_s[6]     = frame_err_r;
      status_s[7]     = err_seen_r;
      status_s[8]     = underflow_r;
      status_s[9]     = (state_r == ST_IN_PKT);
      status_s[31:16] = 16'(level_r);
      case (addr_s)
         2'd0:    rd_mux_s = nonempty_s ? head_s[DATA_WIDTH-1:0] : {DATA_WIDTH{1'b0}};
         2'd1:    rd_mux_s = DATA_WIDTH'(status_s);
         2'd2:    rd_mux_s = {DATA_WIDTH{1'b0}};
         2'd3:    rd_mux_s = DATA_WIDTH'(pkt_cnt_r);
         default: rd_mux_s = {DATA_WIDTH{1'b0}};
      endcase
   end

   // Beat storage; contents are only meaningful between rd_ptr and wr_ptr.
   always_ff @(posedge Clk_CI) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= {StError_SI, StEmpty_SI, StEop_SI, StSop_SI, StData_DI};
      end
   end

   // FIFO pointers, fill level and framing state.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         wr_ptr_r   <= PTR_ZERO;
         rd_ptr_r   <= PTR_ZERO;
         level_r    <= LVL_ZERO;
         state_r    <= ST_IDLE;
         ready_en_r <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         ready_en_r <= 1'b1;
         if (flush_s) begin
            wr_ptr_r <= PTR_ZERO;
            rd_ptr_r <= PTR_ZERO;
            level_r  <= LVL_ZERO;
         end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
            case ({push_s, pop_s})
               2'b10:   level_r <= level_r + LVL_ONE;
               2'b01:   level_r <= level_r - LVL_ONE;
               default: level_r <= level_r;
            endcase
         end
      end
   end

   // Two-cycle read: capture in the stall cycle, pop/underflow take effect at the end of the second.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         rd_phase_r <= 1'b0;
         pop_pend_r <= 1'b0;
         unf_pend_r <= 1'b0;
         readdata_r <= {DATA_WIDTH{1'b0}};
      end else begin
         rd_phase_r <= rd_start_s;
         if (rd_start_s) begin
            readdata_r <= rd_mux_s;
            pop_pend_r <= (addr_s == 2'd0) & nonempty_s;
            unf_pend_r <= (addr_s == 2'd0) & ~nonempty_s;
         end
      end
   end

   // Sticky flags (a new event beats a clear) and the packet counter.
   always_ff @(posedge Clk_CI or negedge Reset_RBI) begin
      if (!Reset_RBI) begin
         frame_err_r <= 1'b0;
         err_seen_r  <= 1'b0;
         underflow_r <= 1'b0;
         pkt_cnt_r   <= 32'h0000_0000;
      end else begin
         frame_err_r <= frame_err_set_s | (frame_err_r & ~clear_s);
         err_seen_r  <= err_seen_set_s | (err_seen_r & ~clear_s);
         underflow_r <= (rd_phase_r & unf_pend_r) | (underflow_r & ~clear_s);
         if (pkt_clr_s) begin
            pkt_cnt_r <= 32'h0000_0000;
         end else if (pkt_inc_s) begin
            pkt_cnt_r <= pkt_cnt_r + 32'h0000_0001;
         end
      end
   end

endmodule

// File: tb/tb_avalon_st_sink_mm_reader.sv
// Scenario-driven bench: stored beats are queued as expectations and popped on DATA reads.
module tb_avalon_st_sink_mm_reader;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        st_ready, st_valid, st_sop, st_eop, st_empty;
   logic [1:0]  st_error;
   logic [31:0] st_data;
   logic [7:0]  mm_addr;
   logic        mm_read, mm_write;
   logic [31:0] mm_wdata, mm_rdata;
   logic        mm_wait;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];

   avalon_st_sink_mm_reader dut (
      .Clk_CI          (clk),
      .Reset_RBI       (rst_n),
      .StReady_SO      (st_ready),
      .StValid_SI      (st_valid),
      .StSop_SI        (st_sop),
      .StEop_SI        (st_eop),
      .StEmpty_SI      (st_empty),
      .StError_SI      (st_error),
      .StData_DI       (st_data),
      .MmAddress_DI    (mm_addr),
      .MmRead_SI       (mm_read),
      .MmWrite_SI      (mm_write),
      .MmWritedata_DI  (mm_wdata),
      .MmReaddata_DO   (mm_rdata),
      .MmWaitrequest_SO(mm_wait)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time exceeded");
      $fatal(1);
   end

   task automatic idle_inputs();
      st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_empty = 1'b0;
      st_error = 2'b00; st_data = 32'h0;
      mm_addr = 8'h00; mm_read = 1'b0; mm_write = 1'b0; mm_wdata = 32'h0;
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      idle_inputs();
      exp_q.delete();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic st_beat(input logic [31:0] d, input logic s, input logic e,
                          input logic [1:0] er, input bit store);
      bit ok = 1'b0;
      @(negedge clk);
      st_valid = 1'b1; st_data = d; st_sop = s; st_eop = e; st_error = er;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (st_ready) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         checks++; errors++;
         $display("FAIL st_accept_timeout data %h", d);
      end else if (store) begin
         exp_q.push_back(d);
      end
      @(negedge clk);
      st_valid = 1'b0; st_sop = 1'b0; st_eop = 1'b0; st_error = 2'b00;
   endtask

   task automatic mm_rd(input logic [7:0] a, output logic [31:0] d, output int waits);
      bit done = 1'b0;
      @(negedge clk);
      mm_addr = a; mm_read = 1'b1; waits = 0;
      for (int i = 0; i < 8; i++) begin
         #1;
         if (!mm_wait) begin
            done = 1'b1;
            break;
         end
         waits++;
         @(negedge clk);
      end
      if (!done) begin
         checks++; errors++;
         $display("FAIL mm_read_timeout addr %h", a);
      end
      d = mm_rdata;
      @(negedge clk);
      mm_read = 1'b0;
   endtask

   task automatic mm_wr(input logic [7:0] a, input logic [31:0] wd);
      @(negedge clk);
      mm_addr = a; mm_write = 1'b1; mm_wdata = wd;
      #1;
      checks++;
      if (mm_wait !== 1'b0) begin
         errors++; $display("FAIL write_wait got %b exp 0", mm_wait);
      end
      @(negedge clk);
      mm_write = 1'b0;
   endtask

   task automatic check_data_read(input string name);
      logic [31:0] d, e;
      int w;
      mm_rd(8'h00, d, w);
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
      checks++;
      if (d !== e) begin
         errors++; $display("FAIL %s data got %h exp %h", name, d, e);
      end
      checks++;
      if (w !== 1) begin
         errors++; $display("FAIL %s waits got %0d exp 1", name, w);
      end
   endtask

   task automatic check_reg(input logic [7:0] a, input logic [31:0] e, input string name);
      logic [31:0] d;
      int w;
      mm_rd(a, d, w);
      checks++;
      if (d !== e) begin
         errors++; $display("FAIL %s got %h exp %h", name, d, e);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      idle_inputs();
      repeat (2) @(negedge clk);
      #1;
      checks++;
      if (st_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", st_ready); end
      checks++;
      if (mm_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h exp 0", mm_rdata); end
      checks++;
      if (mm_wait !== 1'b0) begin errors++; $display("FAIL reset_wait got %b exp 0", mm_wait); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      checks++;
      if (st_ready !== 1'b0) begin errors++; $display("FAIL release_ready got %b exp 0", st_ready); end
      @(negedge clk);
      #1;
      checks++;
      if (st_ready !== 1'b1) begin errors++; $display("FAIL post_release_ready got %b exp 1", st_ready); end
      check_reg(8'h01, 32'h0000_0000, "reset_status");
      check_reg(8'h03, 32'h0000_0000, "reset_pktcnt");
   endtask

   task automatic test_packet();
      apply_reset();
      st_beat(32'hA0, 1'b1, 1'b0, 2'b00, 1'b1);
      st_beat(32'hA1, 1'b0, 1'b0, 2'b00, 1'b1);
      st_beat(32'hA2, 1'b0, 1'b1, 2'b00, 1'b1);
      check_reg(8'h01, 32'h0003_0003, "pkt_status");
      check_reg(8'h03, 32'h0000_0001, "pkt_pktcnt");
      for (int i = 0; i < 3; i++) check_data_read("pkt_read");
      check_reg(8'h01, 32'h0000_0000, "pkt_status_drained");
   endtask

   task automatic test_fill();
      apply_reset();
      for (int i = 0; i < 16; i++) st_beat(32'hB0 + i, (i == 0), 1'b0, 2'b00, 1'b1);
      #1;
      checks++;
      if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", st_ready); end
      check_reg(8'h01, 32'h0010_0203, "full_status");
      #1;
      checks++;
      if (st_ready !== 1'b0) begin errors++; $display("FAIL full_ready_hold got %b exp 0", st_ready); end
      check_data_read("full_pop");
      #1;
      checks++;
      if (st_ready !== 1'b1) begin errors++; $display("FAIL after_pop_ready got %b exp 1", st_ready); end
      check_reg(8'h01, 32'h000F_0201, "after_pop_status");
   endtask

   task automatic test_frame_err();
      apply_reset();
      st_beat(32'hC0, 1'b0, 1'b0, 2'b00, 1'b0);
      check_reg(8'h01, 32'h0000_0040, "frame_err_status");
      mm_wr(8'h02, 32'h0000_0002);
      check_reg(8'h01, 32'h0000_0000, "frame_err_cleared");
   endtask

   task automatic test_underflow();
      apply_reset();
      check_data_read("underflow_read");
      check_reg(8'h01, 32'h0000_0100, "underflow_status");
   endtask

   task automatic test_back_to_back();
      logic [31:0] d, e;
      apply_reset();
      for (int i = 0; i < 5; i++) st_beat(32'hD0 + i, (i == 0), 1'b0, 2'b00, 1'b1);
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         mm_addr = 8'h00; mm_read = 1'b1;
         #1;
         checks++;
         if (mm_wait !== 1'b1) begin errors++; $display("FAIL b2b_wait1 got %b exp 1", mm_wait); end
         @(negedge clk);
         st_valid = 1'b1; st_data = 32'hE0 + k; st_sop = 1'b0; st_eop = 1'b0;
         #1;
         checks++;
         if (mm_wait !== 1'b0 || st_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_cycle2 wait %b ready %b exp 0 1", mm_wait, st_ready);
         end
         d = mm_rdata;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'h0;
         exp_q.push_back(32'hE0 + k);
         checks++;
         if (d !== e) begin errors++; $display("FAIL b2b_data got %h exp %h", d, e); end
         @(negedge clk);
         mm_read = 1'b0; st_valid = 1'b0;
      end
      check_reg(8'h01, 32'h0005_0201, "b2b_status");
      for (int i = 0; i < 5; i++) check_data_read("b2b_drain");
   endtask

   task automatic test_flush();
      apply_reset();
      st_beat(32'hF0, 1'b1, 1'b0, 2'b01, 1'b1);
      st_beat(32'hF1, 1'b0, 1'b0, 2'b00, 1'b1);
      check_reg(8'h01, 32'h0002_0293, "flush_pre_status");
      mm_wr(8'h02, 32'h0000_0001);
      exp_q.delete();
      check_reg(8'h01, 32'h0000_0080, "flush_post_status");
      st_beat(32'hF2, 1'b1, 1'b1, 2'b00, 1'b1);
      check_reg(8'h03, 32'h0000_0001, "flush_pktcnt");
      mm_wr(8'h03, 32'hDEAD_BEEF);
      check_reg(8'h03, 32'h0000_0000, "pktcnt_cleared");
      mm_wr(8'h02, 32'h0000_0003);
      exp_q.delete();
      check_reg(8'h01, 32'h0000_0000, "flush_clear_status");
   endtask

   task automatic test_reset_mid();
      apply_reset();
      for (int i = 0; i < 7; i++) st_beat(32'h70 + i, (i == 0), 1'b0, 2'b00, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      checks++;
      if (st_ready !== 1'b0) begin errors++; $display("FAIL midreset_ready got %b exp 0", st_ready); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      #1;
      checks++;
      if (st_ready !== 1'b1) begin errors++; $display("FAIL midreset_release_ready got %b exp 1", st_ready); end
      check_reg(8'h01, 32'h0000_0000, "midreset_status");
      check_reg(8'h03, 32'h0000_0000, "midreset_pktcnt");
   endtask

   initial begin
      test_reset();
      test_packet();
      test_fill();
      test_frame_err();
      test_underflow();
      test_back_to_back();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
